pellet_board_arbiter: RTL
=========================

# pellet_board_arbiter

Owns the 31×28 pellet bitmap that drives the maze renderer, and sequences every write to it. Three requesters share one row-write port: a refill sequencer, a hardware eat detector driven by the Pac-Man position from pm_animator, and software row writes forwarded from the AXI register block. The block maintains a running pellet count and flags an empty board for game logic.

## Interface
Parameters:
- ROWS, 31, bitmap rows.
- COLS, 28, bits per row.
- TILE_SHIFT, 3, log2 of tile size in pixels (8-px tiles).

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  reset; one clock, synchronous, active-high.
- pm_x  in  32  Pac-Man pixel X.
- pm_y  in  32  Pac-Man pixel Y.
- sw_req  in  1  software row-write request; level, held until sw_ack.
- sw_row  in  5  target row; stable while sw_req=1.
- sw_data  in  COLS  new row contents; stable while sw_req=1.
- sw_ack  out  1  one-cycle pulse on the edge the software write commits.
- refill  in  1  pulse; start full-board refill.
- busy  out  1  refill in progress.
- pellets  out  COLS × [0:ROWS-1]  registered bitmap; bit=1 means pellet present.
- pellet_count  out  10  pellets remaining (max 868).
- eat_pulse  out  1  one-cycle pulse per pellet eaten.
- board_clear  out  1  pellet_count==0, combinational from count register.

## Operation
- Reset: all pellets rows = all ones, pellet_count=868, state IDLE, row counter 0, busy=0, sw_ack=0, eat_pulse=0.
- FSM states: IDLE, FILL.
  - IDLE→FILL on refill=1; row counter cleared to 0.
  - FILL: each cycle writes the row at the row counter with all ones, then increments the counter. After the row ROWS-1 write, go to IDLE and load pellet_count=ROWS*COLS.
  - refill while in FILL is ignored. busy=1 exactly while in FILL.
- Eat detector, two stages:
  - Stage 1 registers tile_col=pm_x>>TILE_SHIFT, tile_row=pm_y>>TILE_SHIFT, and valid=(tile_col<COLS)&&(tile_row<ROWS), computed on the full 32-bit values.
  - Stage 2: if valid, pellets[tile_row][tile_col]==1 and state is IDLE, clear that bit, pulse eat_pulse, and decrement pellet_count.
  - During FILL the eat is dropped, not queued. Stage 1 re-evaluates every cycle, so a stationary Pac-Man eats after FILL ends.
- Software write:
  - Granted when state is IDLE and no eat write is committing that cycle.
  - On grant: pellets[sw_row] = sw_data, sw_ack pulses, and pellet_count += popcount(sw_data) − popcount(old row).
  - sw_row ≥ ROWS: acked with no bitmap or count change.
- Priority, one write per cycle: FILL > eat > software.
  - Eat and software targeting the same row in the same cycle: eat commits first; software commits the next cycle and overwrites the whole row, including the cleared bit.
- pellet_count never wraps. The decrement only occurs on a set bit, and software deltas are exact.

## Timing
- Position change at edge N → stage 1 registered at N → bit cleared, eat_pulse high, and count updated at edge N+1. Updated pellets are visible in the cycle after N+1.
- Back-to-back same tile: stage 2 at N+2 reads the already-cleared bit, so there is no second pulse.
- sw_ack latency: 1 cycle after sw_req rises if uncontended. Each losing cycle against eat adds 1. During FILL, sw_ack is delayed until FILL completes.
- Refill: busy rises the edge after refill; the FILL phase spans exactly ROWS=31 cycles of row writes, then IDLE.
- Reset mid-FILL or mid-handshake returns to reset values next edge. A pending sw_req is re-arbitrated after reset; it is not auto-acked.

## Test plan
- Reset → all 31 rows = 0x0FFFFFFF, pellet_count=868, busy=0, board_clear=0.
- pm_x=20, pm_y=12 (tile col 2, row 1) → eat_pulse one cycle, 2 edges later; pellets[1][2]=0; count=867; position held 10 cycles → no further pulses.
- sw_req with sw_row=5, sw_data=0 → sw_ack after 1 cycle; pellets[5]=0; count 868→840. Then sw_data=0x0FFFFFFF on row 5 → count 868.
- Same-cycle eat at (col 0, row 3) and software write of row 3=0x0000000F → eat_pulse first, sw_ack next cycle; final row 3=0x0000000F; count consistent with popcounts.
- Clear all rows by software → board_clear=1. refill → busy high for 31 cycles, rows restored, count=868. Eat and sw_req during FILL → neither commits until IDLE.
- pm_x=224 (col 28) or pm_y=248 (row 31) → no eat_pulse; bitmap unchanged.

Source files
------------

// File: rtl/pellet_board_arbiter.sv
// Pellet bitmap owner: arbitrates refill, hardware eat and software row writes
// onto a single row-write port and keeps a running pellet count.
module pellet_board_arbiter #(
  parameter int ROWS       = 31,
  parameter int COLS       = 28,
  parameter int TILE_SHIFT = 3
) (
  input  logic            S_AXI_ACLK,
  input  logic            S_AXI_ARESET,
  input  logic [31:0]     pm_x,
  input  logic [31:0]     pm_y,
  input  logic            sw_req,
  input  logic [4:0]      sw_row,
  input  logic [COLS-1:0] sw_data,
  output logic            sw_ack,
  input  logic            refill,
  output logic            busy,
  output logic [COLS-1:0] pellets [0:ROWS-1],
  output logic [9:0]      pellet_count,
  output logic            eat_pulse,
  output logic            board_clear
);

  localparam int          COL_W    = $clog2(COLS);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
  localparam logic [9:0]  TOTAL    = 10'(ROWS * COLS);
  localparam logic [31:0] COLS32   = 32'(COLS);
  localparam logic [31:0] ROWS32   = 32'(ROWS);

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state_q, state_d;
  logic [4:0]       fill_row_q, fill_row_d;

  // Eat detector stage 1: tile coordinates of the current Pac-Man position.
  logic [31:0]      tile_col, tile_row;
  logic [COL_W-1:0] s1_col;
  logic [4:0]       s1_row;
  logic             s1_valid;

  logic             wr_en;
  logic [4:0]       wr_row;
  logic [COLS-1:0]  wr_data;
  logic [9:0]       count_d;
  logic             eat_commit;
  logic             sw_grant;

  function automatic logic [9:0] popcount(input logic [COLS-1:0] v);
    logic [9:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) n = n + {9'd0, v[i]};
    return n;
  endfunction

  assign tile_col    = pm_x >> TILE_SHIFT;
  assign tile_row    = pm_y >> TILE_SHIFT;
  assign busy        = (state_q == FILL);
  assign board_clear = (pellet_count == '0);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    fill_row_d = fill_row_q;
    wr_en      = 1'b0;
    wr_row     = fill_row_q;
    wr_data    = '1;
    count_d    = pellet_count;
    eat_commit = 1'b0;
    sw_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (s1_valid && pellets[s1_row][s1_col]) begin
          eat_commit = 1'b1;
          wr_en      = 1'b1;
          wr_row     = s1_row;
          wr_data    = pellets[s1_row] & ~(COLS'(1) << s1_col);
          count_d    = pellet_count - 10'd1;
        end else if (sw_req && !sw_ack) begin
          // sw_req is still high during the ack cycle; that is the same
          // request, so it is not granted twice.
          sw_grant = 1'b1;
          if (sw_row <= ROW_LAST) begin
            wr_en   = 1'b1;
            wr_row  = sw_row;
            wr_data = sw_data;
            count_d = pellet_count - popcount(pellets[sw_row]) + popcount(sw_data);
          end
        end
        if (refill) begin
          state_d    = FILL;
          fill_row_d = '0;
        end
      end
      FILL: begin
        wr_en   = 1'b1;
        wr_row  = fill_row_q;
        wr_data = '1;
        if (fill_row_q == ROW_LAST) begin
          state_d = IDLE;
          count_d = TOTAL;
        end else begin
          fill_row_d = fill_row_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q      <= IDLE;
      fill_row_q   <= '0;
      pellet_count <= TOTAL;
      sw_ack       <= 1'b0;
      eat_pulse    <= 1'b0;
      s1_col       <= '0;
      s1_row       <= '0;
      s1_valid     <= 1'b0;
      // NOTE: the bitmap is a flop array read in parallel by the renderer, so
      // it can be reset; a RAM-backed store could not be cleared this way.
      for (int r = 0; r < ROWS; r++) pellets[r] <= '1;
    end else begin
      // NOTE: non-blocking assignments for all state, so every reader in this
      // edge sees the pre-edge values regardless of statement order.
      state_q      <= state_d;
      fill_row_q   <= fill_row_d;
      pellet_count <= count_d;
      sw_ack       <= sw_grant;
      eat_pulse    <= eat_commit;
      s1_col       <= tile_col[COL_W-1:0];
      s1_row       <= tile_row[4:0];
      s1_valid     <= (tile_col < COLS32) && (tile_row < ROWS32);
      if (wr_en) pellets[wr_row] <= wr_data;
    end
  end

endmodule
